ram_bus_arbiter: RTL and testbench
==================================

# ram_bus_arbiter

Round-robin arbiter and sequencer that shares the single-port RAM slave (cs/rw/addr/data_in → ready/data_out) among NUM_REQ requesters. It latches one requester's command, drives the slave's chip-select handshake through its IDLE→RUN→DONE sequence, and returns read data with a one-cycle acknowledge. A watchdog aborts accesses the slave never completes. It sits between the bus masters (CPU BFM, DMA) and the RAM slave.

## Interface
- NUM_REQ, 2, number of requesters (2..8); IDX_W = $clog2(NUM_REQ).
- TIMEOUT, 15, cycles with cs high and no ready before abort (≥3).
- clk  in  1  clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  [NUM_REQ]  request pending; held with its fields until its req_ack.
- req_rw  in  [NUM_REQ]  1 = read, 0 = write.
- req_addr  in  [NUM_REQ][16]  byte address; bits [1:0] are passed through and ignored by the slave.
- req_wdata  in  [NUM_REQ][32]  write data.
- req_ack  out  [NUM_REQ]  one-hot, one-cycle completion pulse.
- req_err  out  1  valid with req_ack; 1 = timed out.
- req_rdata  out  32  read data; valid with req_ack on reads; 0 otherwise.
- ram_cs / ram_rw / ram_addr[16] / ram_data_in[32]  out  slave command, all registered.
- ram_ready  in  1  slave completion strobe.
- ram_data_out  in  32  slave read data, valid while ram_ready = 1.

## Operation
- States: S_IDLE, S_ACCESS, S_GAP.
- S_IDLE: when any req_valid is high, the winner is the first set bit searching upward from last_grant+1 (mod NUM_REQ). Register the winner's rw/addr/wdata onto ram_*, set ram_cs = 1, store grant index, clear watchdog, → S_ACCESS. No request: stay, ram_cs = 0.
- S_ACCESS: ram_cs held 1 and command stable. On ram_ready = 1: capture ram_data_out (reads) into req_rdata, pulse req_ack[grant], req_err = 0, ram_cs ← 0, last_grant ← grant, → S_GAP. When watchdog reaches TIMEOUT without ready: pulse req_ack[grant] with req_err = 1, req_rdata = 0, ram_cs ← 0, last_grant ← grant, → S_GAP.
- S_GAP: ram_cs = 0 for exactly one cycle so the slave returns to its idle state; → S_IDLE unconditionally.
- req_valid dropping during S_ACCESS is ignored; the access completes and is acknowledged.
- ram_ready outside S_ACCESS is ignored.
- Writes: req_rdata = 0 on the ack cycle.
- Reset values: ram_cs = 0, ram_rw = 0, ram_addr = 0, ram_data_in = 0, req_ack = 0, req_err = 0, req_rdata = 0, state = S_IDLE, last_grant = NUM_REQ-1 so requester 0 wins first. Reset mid-access aborts without an ack.

## Timing
- Edge E0: S_IDLE sees a request and ram_cs goes high.
- E1: slave enters RUN.
- E2: ram_ready = 1.
- E3: req_ack/req_rdata are registered and ram_cs drops.
- E4: S_GAP → S_IDLE.
- E5: earliest next ram_cs.
- Request-to-ack latency is 3 cycles from the first S_IDLE cycle with req_valid high. Throughput is one access per 5 cycles.
- Timeout ack occurs TIMEOUT+1 edges after ram_cs rises.
- A requester that keeps req_valid high after its ack is re-arbitrated at E5 and competes normally. Round-robin makes it yield to any other pending requester.

## Structure
- Package ram_bus_arb_pkg: ADDR_W = 16, DATA_W = 32, and the state enum typedef (S_IDLE, S_ACCESS, S_GAP).
- Sub-module rr_pick: purely combinational; inputs req vector and last_grant, outputs any and grant index. It is instantiated once and unit-testable alone.
- Top-level holds the FSM, command registers, watchdog counter and ack/rdata registers.

## Test plan
- Single write then read, NUM_REQ=2: requester 0 writes 0xDEADBEEF @0x0010, then reads @0x0010 → each req_ack[0] 3 cycles after request; read req_rdata = 0xDEADBEEF, req_err = 0.
- Contention: req_valid = 2'b11 held continuously after reset → grants alternate 0,1,0,1; acks 5 cycles apart; ram_cs low for exactly 1 cycle between accesses.
- Round-robin skip, NUM_REQ=4: last_grant = 1, req_valid = 4'b1001 → requester 3 granted before requester 0.
- Timeout: slave model never asserts ram_ready, TIMEOUT=15 → req_ack pulses with req_err = 1 and req_rdata = 0 at edge 16 after ram_cs rises; next request proceeds normally.
- Reset mid-access: assert reset_n low at E1 → ram_cs and all acks go 0 immediately with no ack; after release, requester 0 has priority.
- Request withdrawn: drop req_valid[1] at E1 of its access → ack still pulses at E3; no second access is issued.

Source files
------------

// File: rtl/ram_bus_arb_pkg.sv
// Shared widths and FSM state type for the RAM bus arbiter.
package ram_bus_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_GAP
  } arb_state_e;

endpackage

// File: rtl/ram_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant_i+1.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   grant_o
);

  logic              found;
  logic [IDX_W-1:0]  pick;
  int unsigned       idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    any_o   = found;
    grant_o = pick;
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one single-port RAM slave among NUM_REQ requesters: round-robin grant,
// registered cs handshake, one-cycle ack and a watchdog that aborts stuck accesses.
module ram_bus_arbiter
  import ram_bus_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic                            req_err,
  output logic [DATA_W-1:0]               req_rdata,
  output logic                            ram_cs,
  output logic                            ram_rw,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_data_in,
  input  logic                            ram_ready,
  input  logic [DATA_W-1:0]               ram_data_out
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                cs_q, cs_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .grant_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    cs_d    = cs_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        cs_d = 1'b0;
        if (pick_any) begin
          rw_d    = req_rw[pick_idx];
          addr_d  = req_addr[pick_idx];
          wdata_d = req_wdata[pick_idx];
          cs_d    = 1'b1;
          grant_d = pick_idx;
          wd_d    = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A ready arriving on the same edge as the watchdog expiry still completes normally.
        if (ram_ready) begin
          if (rw_q) rdata_d = ram_data_out;
          ack_d[grant_q] = 1'b1;
          cs_d    = 1'b0;
          last_d  = grant_q;
          state_d = S_GAP;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          ack_d[grant_q] = 1'b1;
          err_d   = 1'b1;
          cs_d    = 1'b0;
          last_d  = grant_q;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_GAP: begin
        cs_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cs_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      wd_q    <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_err     = err_q;
  assign req_rdata   = rdata_q;
  assign ram_cs      = cs_q;
  assign ram_rw      = rw_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed and randomized bench for ram_bus_arbiter with a RAM slave model and
// a transaction-level reference (round-robin order, latency, memory contents).
module tb_ram_bus_arbiter;

  localparam int NR = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]        valid, rw;
  logic [NR-1:0][15:0]  addr;
  logic [NR-1:0][31:0]  wdata;
  logic [NR-1:0]        ack;
  logic                 err;
  logic [31:0]          rdata;
  logic                 cs, ram_rw;
  logic [15:0]          ram_addr;
  logic [31:0]          ram_din, ram_dout;
  logic                 ready;
  logic                 stall;

  ram_bus_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (valid),
    .req_rw       (rw),
    .req_addr     (addr),
    .req_wdata    (wdata),
    .req_ack      (ack),
    .req_err      (err),
    .req_rdata    (rdata),
    .ram_cs       (cs),
    .ram_rw       (ram_rw),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_din),
    .ram_ready    (ready),
    .ram_data_out (ram_dout)
  );

  // RAM slave: IDLE -> RUN -> DONE (ready) -> IDLE once cs drops; memory clears on reset.
  logic [1:0]  sst;
  logic [31:0] smem [16];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sst      <= 2'd0;
      ready    <= 1'b0;
      ram_dout <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      case (sst)
        2'd0: if (cs) sst <= 2'd1;
        2'd1: begin
          if (!cs) sst <= 2'd0;
          else if (!stall) begin
            sst   <= 2'd2;
            ready <= 1'b1;
            if (ram_rw) ram_dout <= smem[ram_addr[5:2]];
            else        smem[ram_addr[5:2]] <= ram_din;
          end
        end
        default: if (!cs) begin
          sst      <= 2'd0;
          ready    <= 1'b0;
          ram_dout <= $urandom;
        end
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_g;
  int          ack_cyc;
  logic [31:0] last_rd;
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge with the arbiter idle and valid != 0; leaves at the negedge after the gap edge.
  task automatic run_access(input bit stall_it, input logic [NR-1:0] drop_e1, input int exp_w);
    int          w, n, exp_n;
    bit          got;
    logic [31:0] exp_rd;
    logic [NR-1:0] exp_ack;
    w = (exp_w >= 0) ? exp_w : rr_model(valid, last_g);
    stall = stall_it;
    tick();
    chk("e0_cs", cs, 1'b1);
    chk("e0_addr", ram_addr, addr[w]);
    chk("e0_rw", ram_rw, rw[w]);
    if (!rw[w]) chk("e0_wdata", ram_din, wdata[w]);
    n = 1;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 2) valid = valid & ~drop_e1;
      if (ack != '0) got = 1'b1;
      else chk("cs_held", cs, 1'b1);
    end
    exp_n = stall_it ? TO + 2 : 4;
    exp_ack = '0;
    exp_ack[w] = 1'b1;
    exp_rd = (stall_it || !rw[w]) ? 32'd0 : ref_mem[addr[w][5:2]];
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", n, exp_n);
    chk("ack_onehot", ack, exp_ack);
    chk("ack_err", err, stall_it);
    chk("ack_rdata", rdata, exp_rd);
    chk("cs_drop", cs, 1'b0);
    last_rd = rdata;
    ack_cyc = cyc;
    if (!stall_it && !rw[w]) ref_mem[addr[w][5:2]] = wdata[w];
    last_g = w;
    stall = 1'b0;
    tick();
    chk("gap_ack", ack, '0);
    chk("gap_cs", cs, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    valid = '0; rw = '0; addr = '0; wdata = '0; stall = 1'b0;
    last_g = NR - 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    repeat (2) tick();
    chk("rst_cs", cs, 1'b0);
    chk("rst_rw", ram_rw, 1'b0);
    chk("rst_addr", ram_addr, 16'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_ack", ack, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("idle_cs", cs, 1'b0);

    // Contention: both held, grants alternate 0,1,0,1 with acks 5 cycles apart.
    rw[0] = 1'b0; addr[0] = 16'h0020; wdata[0] = 32'h1234_5678;
    rw[1] = 1'b1; addr[1] = 16'h0027;
    valid = 4'b0011;
    run_access(1'b0, '0, 0);
    prev = ack_cyc;
    for (int k = 1; k < 4; k++) begin
      run_access(1'b0, '0, k % 2);
      chk("ack_spacing", ack_cyc - prev, 5);
      prev = ack_cyc;
    end
    valid = '0;
    tick();

    // Single write then read on requester 0.
    rw[0] = 1'b0; addr[0] = 16'h0010; wdata[0] = 32'hDEAD_BEEF;
    valid = 4'b0001;
    run_access(1'b0, '0, 0);
    rw[0] = 1'b1;
    run_access(1'b0, '0, 0);
    chk("readback", last_rd, 32'hDEAD_BEEF);
    valid = '0;

    // Round-robin skip: after grant 1, {3,0} pending -> 3 then 0.
    rw[1] = 1'b0; addr[1] = 16'h0004; wdata[1] = 32'hA5A5_0001;
    valid = 4'b0010;
    run_access(1'b0, '0, 1);
    rw[3] = 1'b0; addr[3] = 16'h0008; wdata[3] = 32'h0303_0303;
    rw[0] = 1'b1; addr[0] = 16'h0008;
    valid = 4'b1001;
    run_access(1'b0, '0, 3);
    valid[3] = 1'b0;
    run_access(1'b0, '0, 0);
    chk("rr_read", last_rd, 32'h0303_0303);
    valid = '0;

    // Timeout, then a normal access.
    rw[2] = 1'b1; addr[2] = 16'h0010;
    valid = 4'b0100;
    run_access(1'b1, '0, 2);
    rw[1] = 1'b1; addr[1] = 16'h0010;
    valid = 4'b0010;
    run_access(1'b0, '0, 1);
    chk("post_to_read", last_rd, 32'hDEAD_BEEF);

    // Withdrawn at E1: still acked, no second access.
    run_access(1'b0, 4'b0010, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("withdrawn_cs", cs, 1'b0);
      chk("withdrawn_ack", ack, '0);
    end

    // Reset mid-access: aborts silently, requester 0 regains priority.
    valid = 4'b0001;
    rw[0] = 1'b1;
    run_access(1'b0, '0, 0);
    rw[2] = 1'b1; addr[2] = 16'h0030;
    valid = 4'b0100;
    tick();
    chk("mid_e0_cs", cs, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs, 1'b0);
    chk("mid_rst_ack", ack, '0);
    chk("mid_rst_err", err, 1'b0);
    valid = 4'b0011;
    rw[0] = 1'b0; addr[0] = 16'h0000; wdata[0] = 32'h0BAD_F00D;
    rw[1] = 1'b1; addr[1] = 16'h0000;
    @(negedge clk);
    tick();
    chk("rst_hold_ack", ack, '0);
    reset_n = 1'b1;
    last_g = NR - 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    run_access(1'b0, '0, 0);
    valid[0] = 1'b0;
    run_access(1'b0, '0, 1);
    chk("post_rst_read", last_rd, 32'h0BAD_F00D);
    valid = '0;

    // Randomized traffic against the reference model.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NR; i++) begin
        if (!valid[i] && $urandom_range(0, 1) == 1) begin
          rw[i]    = 1'($urandom_range(0, 1));
          addr[i]  = {10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
          wdata[i] = $urandom;
          valid[i] = 1'b1;
        end
      end
      if (valid == '0) begin
        tick();
        chk("rand_idle_cs", cs, 1'b0);
      end else begin
        run_access($urandom_range(0, 9) == 0, '0, -1);
        if ($urandom_range(0, 1) == 1) valid[last_g] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
